// File: rtl/cmd_reg_target_pkg.sv
// Shared types and constants for the command-interface register target.
package cmd_reg_target_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        WAIT_REL
    } cmd_tgt_state_e;

    localparam int unsigned CMD_WORD_LSB = 2;
    localparam logic [31:0] CMD_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/cmd_reg_target.sv
// Register-bank responder on one demux select line: latches a command, performs
// one register access, acks for a single cycle, then waits for select release.
module cmd_reg_target
    import cmd_reg_target_pkg::*;
#(
    parameter int unsigned               NUM_REGS             = 16,
    parameter int unsigned               TARGETS_ADDRESS_BITS = 16,
    parameter int unsigned               HOST_DATA_BITS       = 32,
    parameter logic [NUM_REGS-1:0]       RO_MASK              = '0,
    parameter logic [HOST_DATA_BITS-1:0] ERR_DATA             = CMD_ERR_DATA
) (
    input  logic                               i_sys_clk,
    input  logic                               i_sys_rst,
    input  logic                               i_sel,
    input  logic                               i_cmd_rd_wr_n,
    input  logic [TARGETS_ADDRESS_BITS-1:0]    i_cmd_byte_addr,
    input  logic [HOST_DATA_BITS-1:0]          i_cmd_wdata,
    output logic                               o_cmd_ack,
    output logic [HOST_DATA_BITS-1:0]          o_cmd_rdata,
    input  logic [NUM_REGS*HOST_DATA_BITS-1:0] i_status,
    output logic [NUM_REGS*HOST_DATA_BITS-1:0] o_regs,
    output logic [NUM_REGS-1:0]                o_wr_strobe,
    output logic [NUM_REGS-1:0]                o_rd_strobe,
    output logic                               o_err
);

    localparam int unsigned IW = TARGETS_ADDRESS_BITS - CMD_WORD_LSB;

    cmd_tgt_state_e state_q, state_d;

    logic                               rd_wr_n_q;
    logic [IW-1:0]                      idx_q;
    logic [HOST_DATA_BITS-1:0]          wdata_q;
    logic [HOST_DATA_BITS-1:0]          rdata_q;
    logic [NUM_REGS*HOST_DATA_BITS-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                wr_strobe_q, rd_strobe_q;
    logic                               err_q;

    logic [NUM_REGS-1:0]                hit;
    logic                               in_range;
    logic [HOST_DATA_BITS-1:0]          rd_word;

    logic unused_addr_lsbs;
    logic unused_status;
    assign unused_addr_lsbs = ^i_cmd_byte_addr[CMD_WORD_LSB-1:0];
    assign unused_status    = ^i_status;

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (i_sel) state_d = ACCESS;
            ACCESS:   state_d = ACK;
            ACK:      state_d = WAIT_REL;
            WAIT_REL: if (!i_sel) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        o_cmd_ack   = (state_q == ACK);
        o_cmd_rdata = rdata_q;
        o_regs      = regs_q;
        o_wr_strobe = wr_strobe_q;
        o_rd_strobe = rd_strobe_q;
        o_err       = err_q;
    end

    // One-hot decode: an index beyond NUM_REGS matches nothing, so in_range falls out of it.
    always_comb begin
        hit     = '0;
        rd_word = '0;
        regs_d  = regs_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            hit[i] = (idx_q == IW'(i));
            if (hit[i]) begin
                rd_word = RO_MASK[i] ? i_status[i*HOST_DATA_BITS +: HOST_DATA_BITS]
                                     : regs_q[i*HOST_DATA_BITS +: HOST_DATA_BITS];
                if (!RO_MASK[i]) regs_d[i*HOST_DATA_BITS +: HOST_DATA_BITS] = wdata_q;
            end
        end
        in_range = |hit;
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            rd_wr_n_q   <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            regs_q      <= '0;
            wr_strobe_q <= '0;
            rd_strobe_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_strobe_q <= '0;
            rd_strobe_q <= '0;
            err_q       <= 1'b0;
            if (state_q == IDLE && i_sel) begin
                rd_wr_n_q <= i_cmd_rd_wr_n;
                idx_q     <= i_cmd_byte_addr[TARGETS_ADDRESS_BITS-1:CMD_WORD_LSB];
                wdata_q   <= i_cmd_wdata;
            end
            if (state_q == ACCESS) begin
                if (!in_range) begin
                    err_q <= 1'b1;
                    if (rd_wr_n_q) rdata_q <= ERR_DATA;
                end else if (rd_wr_n_q) begin
                    rdata_q     <= rd_word;
                    rd_strobe_q <= hit;
                end else begin
                    // RO slots are masked out of both the strobe and the regs_d update.
                    wr_strobe_q <= hit & ~RO_MASK;
                    regs_q      <= regs_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmd_reg_target.sv
// Scoreboard bench for cmd_reg_target: driver pushes expected responses, monitor checks on ack.
module tb_cmd_reg_target;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam logic [N-1:0] RO = 16'h0220;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sel = 1'b0;
    logic              rw  = 1'b0;
    logic [AW-1:0]     addr = '0;
    logic [DW-1:0]     wdata = '0;
    logic              ack;
    logic [DW-1:0]     rdata;
    logic [N*DW-1:0]   status = '0;
    logic [N*DW-1:0]   regs;
    logic [N-1:0]      wr_stb, rd_stb;
    logic              err;

    cmd_reg_target #(
        .NUM_REGS(N),
        .TARGETS_ADDRESS_BITS(AW),
        .HOST_DATA_BITS(DW),
        .RO_MASK(RO),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .i_sys_clk(clk),
        .i_sys_rst(rst),
        .i_sel(sel),
        .i_cmd_rd_wr_n(rw),
        .i_cmd_byte_addr(addr),
        .i_cmd_wdata(wdata),
        .o_cmd_ack(ack),
        .o_cmd_rdata(rdata),
        .i_status(status),
        .o_regs(regs),
        .o_wr_strobe(wr_stb),
        .o_rd_strobe(rd_stb),
        .o_err(err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int unsigned   ack_cyc;
        logic [31:0]   rdata;
        logic [15:0]   wr_stb;
        logic [15:0]   rd_stb;
        logic          err;
        logic [511:0]  regs;
    } exp_t;

    exp_t        sbq[$];
    int          tests = 0;
    int          fails = 0;

    logic [31:0] mregs [N];
    logic [31:0] last_rdata;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_regs();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = mregs[i];
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ack) begin
                if (sbq.size() == 0) begin
                    check("spurious_ack", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("ack_latency", cyc, e.ack_cyc);
                    check("rdata", rdata, e.rdata);
                    check("wr_strobe", wr_stb, e.wr_stb);
                    check("rd_strobe", rd_stb, e.rd_stb);
                    check("err", err, e.err);
                    check("regs", regs, e.regs);
                end
            end else begin
                check("idle_pulses", {wr_stb, rd_stb, err}, '0);
            end
        end
    end

    // Issue one select assertion held for `hold` edges; the expected response comes from the model.
    task automatic access(input logic rd, input logic [15:0] a, input logic [31:0] d, input int hold);
        exp_t        e;
        int unsigned idx;
        logic        inr, ro;
        logic [15:0] rom;
        int          lows;
        rom = RO;
        idx = a[15:2];
        inr = idx < N;
        ro  = inr && rom[idx];
        e.ack_cyc = cyc + 2;
        e.wr_stb  = '0;
        e.rd_stb  = '0;
        e.err     = !inr;
        if (rd) begin
            if (!inr)    last_rdata = 32'hDEAD_BEEF;
            else if (ro) last_rdata = status[idx*32 +: 32];
            else         last_rdata = mregs[idx];
            if (inr) e.rd_stb = 16'(1) << idx;
        end else if (inr && !ro) begin
            mregs[idx] = d;
            e.wr_stb   = 16'(1) << idx;
        end
        e.rdata = last_rdata;
        e.regs  = model_regs();
        sbq.push_back(e);
        rw = rd; addr = a; wdata = d; sel = 1'b1;
        repeat (hold) @(posedge clk);
        #1 sel = 1'b0;
        lows = (hold >= 3) ? 1 : 4 - hold;
        repeat (lows) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        last_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        check("rst_regs", regs, 0);
        check("rst_pulses", {wr_stb, rd_stb, err}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        access(1'b0, 16'h0008, 32'h1234_5678, 1);
        access(1'b1, 16'h0008, 32'h0, 2);

        status[5*32 +: 32] = 32'hCAFE_0001;
        access(1'b0, 16'h0014, 32'hFFFF_FFFF, 3);
        access(1'b1, 16'h0014, 32'h0, 1);

        access(1'b1, 16'h0040, 32'h0, 2);
        access(1'b0, 16'h0040, 32'h5555_AAAA, 2);

        access(1'b0, 16'h000C, 32'h0BAD_F00D, 10);
        access(1'b1, 16'h000C, 32'h0, 1);

        access(1'b0, 16'h000B, 32'h7777_0002, 1);
        access(1'b1, 16'h0008, 32'h0, 1);

        // Reset while the write to register 2 sits in ACCESS; that access never acks.
        rw = 1'b0; addr = 16'h0008; wdata = 32'hAAAA_5555; sel = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        sel = 1'b0;
        #1;
        check("midrst_ack", ack, 0);
        check("midrst_regs", regs, 0);
        check("midrst_rdata", rdata, 0);
        for (int i = 0; i < 16; i++) mregs[i] = '0;
        last_rdata = '0;
        @(posedge clk);
        #1 check("midrst_ack_hold", ack, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        access(1'b1, 16'h0008, 32'h0, 2);

        for (int n = 0; n < 80; n++) begin
            logic [15:0] a;
            for (int w = 0; w < 16; w++) status[w*32 +: 32] = $urandom;
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 16'hFFFF));
            else a = {12'($urandom_range(0, 19)), 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 5));
        end

        for (int t = 0; t < 50 && sbq.size() != 0; t++) @(posedge clk);
        check("pending_acks", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
